// File: rtl/dpram_arb_pkg.sv
// Shared types for the dual-port RAM port-B arbiter.
// State encoding and default RAM geometry.
package dpram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } arb_state_t;

  localparam int ADDR_W_DEF = 14;
  localparam int DATA_W_DEF = 8;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin select: first set request
// at or after ptr, wrapping at N.
module rr_pick
  import dpram_arb_pkg::*;
#(
  parameter int N  = 3,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic          valid,
  output logic [PW-1:0] idx
);

  logic [PW:0] s;

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    s     = '0;
    for (int k = 0; k < N; k++) begin
      s = {1'b0, ptr} + (PW+1)'(k);
      if (s >= (PW+1)'(N))
        s = s - (PW+1)'(N);
      if (!valid && req[s[PW-1:0]]) begin
        valid = 1'b1;
        idx   = s[PW-1:0];
      end
    end
  end

endmodule

// File: rtl/dpram_b_arbiter.sv
// Round-robin sequencer sharing RAM port B between
// NUM_REQ requesters, with a watchdog on b_ack.
module dpram_b_arbiter
  import dpram_arb_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = 15,
  localparam int GW     = $clog2(NUM_REQ)
) (
  input  logic                      clk_sys,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        ack,
  output logic [NUM_REQ-1:0]        err,
  output logic [DATA_W-1:0]         rdata,
  output logic                      busy,
  output logic [GW-1:0]             grant_id,
  output logic                      ram_cs_b,
  output logic                      ram_we_b,
  output logic [ADDR_W-1:0]         ram_ad_b,
  output logic [DATA_W-1:0]         ram_d_b,
  input  logic                      b_ack,
  input  logic [DATA_W-1:0]         ram_q_b
);

  arb_state_t state, state_d;

  logic [GW-1:0]      ptr;
  logic               we_q;
  logic [3:0]         cnt, cnt_d;
  logic               pick_valid;
  logic [GW-1:0]      pick_idx;
  logic               latch, capture;
  logic [NUM_REQ-1:0] gnt_oh;

  logic [ADDR_W-1:0] addr_a  [NUM_REQ];
  logic [DATA_W-1:0] wdata_a [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_a[g]  = req_addr[g*ADDR_W +: ADDR_W];
    assign wdata_a[g] = req_wdata[g*DATA_W +: DATA_W];
  end

  rr_pick #(
    .N  (NUM_REQ),
    .PW (GW)
  ) u_pick (
    .req   (req),
    .ptr   (ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign gnt_oh = NUM_REQ'(1) << grant_id;

  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    latch    = 1'b0;
    capture  = 1'b0;
    ack      = '0;
    err      = '0;
    ram_cs_b = 1'b0;
    ram_we_b = 1'b0;
    busy     = 1'b0;
    unique case (state)
      IDLE: begin
        if (pick_valid) begin
          latch   = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        ram_cs_b = 1'b1;
        ram_we_b = we_q;
        busy     = 1'b1;
        cnt_d    = '0;
        state_d  = WAIT;
      end
      WAIT: begin
        busy = 1'b1;
        if (b_ack) begin
          capture = 1'b1;
          state_d = DONE;
        end else if (cnt == 4'(TIMEOUT)) begin
          err     = gnt_oh;
          state_d = IDLE;
        end else begin
          cnt_d = cnt + 4'd1;
        end
      end
      DONE: begin
        ack     = gnt_oh;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Requester inputs are sampled only on the IDLE->ISSUE edge
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      ptr      <= '0;
      grant_id <= '0;
      we_q     <= 1'b0;
      ram_ad_b <= '0;
      ram_d_b  <= '0;
      rdata    <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      if (latch) begin
        grant_id <= pick_idx;
        we_q     <= req_we[pick_idx];
        ram_ad_b <= addr_a[pick_idx];
        ram_d_b  <= wdata_a[pick_idx];
        ptr      <= (pick_idx == GW'(NUM_REQ-1))
                    ? '0 : pick_idx + GW'(1);
      end
      if (capture)
        rdata <= ram_q_b;
    end
  end

endmodule
